// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bank_arbiter
//  Purpose  : Round-robin arbiter that serialises JK commands from several
//             requesters onto a shared bank of JK flip-flops it owns.
//  Revision : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
   parameter int NREQ = 4,
   parameter int NFF  = 6,
   parameter int IDXW = 3
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic [NREQ-1:0]      iReq,
   input  logic [NREQ-1:0]      iJ,
   input  logic [NREQ-1:0]      iK,
   input  logic [NREQ*IDXW-1:0] iIdx,
   output logic [NREQ-1:0]      oGnt,
   output logic                 oBusy,
   output logic                 oErr,
   output logic [NFF-1:0]       oQ,
   output logic [NFF-1:0]       oQn
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_APPLY = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [PTRW-1:0]   r_ptr;
   logic [PTRW-1:0]   w_win;
   logic              w_found;
   logic              w_win_j;
   logic              w_win_k;
   logic [IDXW-1:0]   w_win_idx;
   logic              w_latch;

   logic              r_cmd_j;
   logic              r_cmd_k;
   logic [IDXW-1:0]   r_cmd_idx;
   logic              w_idx_ok;

   logic [NREQ-1:0]   r_gnt;
   logic              r_busy;
   logic              r_err;
   logic [NFF-1:0]    r_q;
   logic [NFF-1:0]    r_qn;

   logic [NREQ-1:0]   w_gnt_nxt;
   logic              w_busy_nxt;
   logic              w_err_nxt;
   logic [NFF-1:0]    w_q_nxt;
   logic [NFF-1:0]    w_q_applied;

   // Winner search: first asserted request at or above the pointer, wrapping.
   always_comb begin
      int w_r;
      w_r       = 0;
      w_found   = 1'b0;
      w_win     = '0;
      w_win_j   = 1'b0;
      w_win_k   = 1'b0;
      w_win_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_r = (int'(r_ptr) + k) % NREQ;
         if (!w_found && iReq[w_r]) begin
            w_found   = 1'b1;
            w_win     = PTRW'(w_r);
            w_win_j   = iJ[w_r];
            w_win_k   = iK[w_r];
            w_win_idx = iIdx[w_r*IDXW +: IDXW];
         end
      end
   end

   assign w_idx_ok = (int'(r_cmd_idx) < NFF);

   // JK update of the addressed flop only; all other flops keep their value.
   always_comb begin
      w_q_applied = r_q;
      for (int i = 0; i < NFF; i++) begin
         if (IDXW'(i) == r_cmd_idx) begin
            case ({r_cmd_j, r_cmd_k})
               2'b10:   w_q_applied[i] = 1'b1;
               2'b01:   w_q_applied[i] = 1'b0;
               2'b11:   w_q_applied[i] = ~r_q[i];
               default: w_q_applied[i] = r_q[i];
            endcase
         end
      end
   end

   // Next-state and next-output decode; outputs are registered one edge later.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_q_nxt     = r_q;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_GRANT;
               w_gnt_nxt   = NREQ'(1) << w_win;
               w_busy_nxt  = 1'b1;
               w_latch     = 1'b1;
            end
         end
         S_GRANT: begin
            w_state_nxt = S_APPLY;
            w_busy_nxt  = 1'b1;
            w_err_nxt   = ~w_idx_ok;
         end
         S_APPLY: begin
            w_state_nxt = S_IDLE;
            if (w_idx_ok) begin
               w_q_nxt = w_q_applied;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command latch, round-robin pointer, bank state and registered outputs.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_ptr     <= '0;
         r_cmd_j   <= 1'b0;
         r_cmd_k   <= 1'b0;
         r_cmd_idx <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_q       <= '0;
         r_qn      <= '1;
      end else begin
         if (w_latch) begin
            r_cmd_j   <= w_win_j;
            r_cmd_k   <= w_win_k;
            r_cmd_idx <= w_win_idx;
            r_ptr     <= PTRW'((int'(w_win) + 1) % NREQ);
         end
         r_gnt  <= w_gnt_nxt;
         r_busy <= w_busy_nxt;
         r_err  <= w_err_nxt;
         r_q    <= w_q_nxt;
         r_qn   <= ~w_q_nxt;
      end
   end

   assign oGnt  = r_gnt;
   assign oBusy = r_busy;
   assign oErr  = r_err;
   assign oQ    = r_q;
   assign oQn   = r_qn;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_bank_arbiter
//  Purpose  : Self-checking bench for jk_bank_arbiter: directed scenarios plus
//             randomized traffic checked against a timeline reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

   localparam int NREQ = 4;
   localparam int NFF  = 6;
   localparam int IDXW = 3;

   logic                 iClk = 1'b0;
   logic                 iRst;
   logic [NREQ-1:0]      iReq;
   logic [NREQ-1:0]      iJ;
   logic [NREQ-1:0]      iK;
   logic [NREQ*IDXW-1:0] iIdx;
   logic [NREQ-1:0]      oGnt;
   logic                 oBusy;
   logic                 oErr;
   logic [NFF-1:0]       oQ;
   logic [NFF-1:0]       oQn;

   int tests = 0;
   int fails = 0;

   jk_bank_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .iReq (iReq),
      .iJ   (iJ),
      .iK   (iK),
      .iIdx (iIdx),
      .oGnt (oGnt),
      .oBusy(oBusy),
      .oErr (oErr),
      .oQ   (oQ),
      .oQn  (oQn)
   );

   always #5 iClk = ~iClk;

   // Reference model: a command accepted at edge t grants at t, flags errors
   // at t+1 and lands in the bank at t+2; requests are sampled only when free.
   logic [NFF-1:0]  m_q;
   int              m_ptr;
   int              m_start;
   int              m_t;
   logic            m_j;
   logic            m_k;
   int              m_idx;
   logic [NREQ-1:0] e_gnt;
   logic            e_busy;
   logic            e_err;

   task automatic model_edge();
      m_t++;
      e_gnt = '0;
      e_err = 1'b0;
      if (iRst) begin
         m_q     = '0;
         m_ptr   = 0;
         m_start = -1;
         e_busy  = 1'b0;
         return;
      end
      if (m_start >= 0) begin
         if (m_t - m_start == 1) begin
            e_busy = 1'b1;
            e_err  = (m_idx >= NFF);
         end else begin
            e_busy = 1'b0;
            if (m_idx < NFF) begin
               if (m_j && m_k)       m_q[m_idx] = ~m_q[m_idx];
               else if (m_j)         m_q[m_idx] = 1'b1;
               else if (m_k)         m_q[m_idx] = 1'b0;
            end
            m_start = -1;
         end
      end else begin
         e_busy = 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            int r = (m_ptr + k) % NREQ;
            if (iReq[r]) begin
               m_j      = iJ[r];
               m_k      = iK[r];
               m_idx    = int'(iIdx[r*IDXW +: IDXW]);
               m_ptr    = (r + 1) % NREQ;
               m_start  = m_t;
               e_gnt[r] = 1'b1;
               e_busy   = 1'b1;
               break;
            end
         end
      end
   endtask

   // One clock: model sees the same inputs as the DUT edge; outputs sampled at negedge.
   task automatic step();
      model_edge();
      @(posedge iClk);
      @(negedge iClk);
   endtask

   // Drive one command from requester r over its three cycles, dropping iReq on grant.
   task automatic issue(input int r, input logic j, input logic k, input logic [IDXW-1:0] idx,
                        output logic [NREQ-1:0] g0, output logic [NREQ-1:0] g1,
                        output logic e1, output logic e2);
      iReq[r] = 1'b1;
      iJ[r]   = j;
      iK[r]   = k;
      iIdx[r*IDXW +: IDXW] = idx;
      step();
      g0 = oGnt;
      iReq[r] = 1'b0;
      step();
      g1 = oGnt;
      e1 = oErr;
      step();
      e2 = oErr;
   endtask

   task automatic test_reset();
      iRst = 1'b1;
      iReq = '1;
      iJ   = 4'b1010;
      iK   = 4'b0110;
      iIdx = 12'hABC;
      step();
      step();
      iReq = '0;
      iRst = 1'b0;
      tests++; if (oQ !== 6'b000000) begin fails++; $display("FAIL reset_q got %b exp %b", oQ, 6'b000000); end
      tests++; if (oQn !== 6'b111111) begin fails++; $display("FAIL reset_qn got %b exp %b", oQn, 6'b111111); end
      tests++; if (oGnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b exp %b", oGnt, 4'b0000); end
      tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", oBusy); end
      tests++; if (oErr !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", oErr); end
      step();
      tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b exp 0", oBusy); end
   endtask

   task automatic test_set();
      logic [NREQ-1:0] g0, g1;
      logic e1, e2;
      issue(0, 1'b1, 1'b0, 3'd2, g0, g1, e1, e2);
      tests++; if (g0 !== 4'b0001) begin fails++; $display("FAIL set_gnt got %b exp %b", g0, 4'b0001); end
      tests++; if (g1 !== 4'b0000) begin fails++; $display("FAIL set_gnt_pulse got %b exp %b", g1, 4'b0000); end
      tests++; if (e1 !== 1'b0 || e2 !== 1'b0) begin fails++; $display("FAIL set_err got %b%b exp 00", e1, e2); end
      tests++; if (oQ !== 6'b000100) begin fails++; $display("FAIL set_q got %b exp %b", oQ, 6'b000100); end
      tests++; if (oQn !== 6'b111011) begin fails++; $display("FAIL set_qn got %b exp %b", oQn, 6'b111011); end
      tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL set_busy_done got %b exp 0", oBusy); end
   endtask

   task automatic test_toggle_clear_hold();
      logic [NREQ-1:0] g0, g1;
      logic e1, e2;
      issue(1, 1'b1, 1'b1, 3'd2, g0, g1, e1, e2);
      tests++; if (g0 !== 4'b0010) begin fails++; $display("FAIL toggle_gnt got %b exp %b", g0, 4'b0010); end
      tests++; if (oQ !== 6'b000000) begin fails++; $display("FAIL toggle_q got %b exp %b", oQ, 6'b000000); end
      issue(1, 1'b0, 1'b1, 3'd5, g0, g1, e1, e2);
      tests++; if (oQ !== 6'b000000) begin fails++; $display("FAIL clear_q got %b exp %b", oQ, 6'b000000); end
      issue(1, 1'b0, 1'b0, 3'd0, g0, g1, e1, e2);
      tests++; if (oQ !== 6'b000000) begin fails++; $display("FAIL hold_q got %b exp %b", oQ, 6'b000000); end
      tests++; if (oQn !== 6'b111111) begin fails++; $display("FAIL hold_qn got %b exp %b", oQn, 6'b111111); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] want;
      iRst = 1'b1;
      iReq = '1;
      iJ   = '1;
      iK   = '0;
      for (int r = 0; r < NREQ; r++) iIdx[r*IDXW +: IDXW] = IDXW'(r);
      step();
      iRst = 1'b0;
      for (int g = 0; g < NREQ + 1; g++) begin
         want = '0;
         want[g % NREQ] = 1'b1;
         step();
         tests++; if (oGnt !== want) begin fails++; $display("FAIL rr_gnt%0d got %b exp %b", g, oGnt, want); end
         step();
         tests++; if (oGnt !== 4'b0000 || oBusy !== 1'b1) begin fails++; $display("FAIL rr_gap%0d gnt %b busy %b exp 0000/1", g, oGnt, oBusy); end
         if (g == NREQ) iReq = '0;
         step();
         tests++; if (oGnt !== 4'b0000) begin fails++; $display("FAIL rr_gap2_%0d got %b exp 0000", g, oGnt); end
      end
      tests++; if (oQ !== 6'b001111) begin fails++; $display("FAIL rr_q got %b exp %b", oQ, 6'b001111); end
   endtask

   task automatic test_err();
      logic [NREQ-1:0] g0, g1;
      logic e1, e2;
      issue(3, 1'b1, 1'b0, 3'd7, g0, g1, e1, e2);
      tests++; if (g0 !== 4'b1000) begin fails++; $display("FAIL err_gnt got %b exp %b", g0, 4'b1000); end
      tests++; if (e1 !== 1'b1) begin fails++; $display("FAIL err_pulse got %b exp 1", e1); end
      tests++; if (e2 !== 1'b0) begin fails++; $display("FAIL err_pulse_end got %b exp 0", e2); end
      tests++; if (oQ !== 6'b001111) begin fails++; $display("FAIL err_q got %b exp %b", oQ, 6'b001111); end
   endtask

   task automatic test_reset_mid();
      iReq[2] = 1'b1; iJ[2] = 1'b1; iK[2] = 1'b0; iIdx[2*IDXW +: IDXW] = 3'd1;
      step();
      tests++; if (oGnt !== 4'b0100) begin fails++; $display("FAIL rstmid_gnt got %b exp %b", oGnt, 4'b0100); end
      iRst = 1'b1;
      iReq[2] = 1'b0;
      step();
      iRst = 1'b0;
      tests++; if (oQ !== 6'b000000 || oGnt !== 4'b0000 || oBusy !== 1'b0 || oErr !== 1'b0)
         begin fails++; $display("FAIL rstmid_abort q %b gnt %b busy %b err %b exp 000000/0000/0/0", oQ, oGnt, oBusy, oErr); end
      step();
      step();
      tests++; if (oQ !== 6'b000000 || oGnt !== 4'b0000) begin fails++; $display("FAIL rstmid_after q %b gnt %b exp 000000/0000", oQ, oGnt); end
      iReq = 4'b1001; iJ = '0; iK = '0;
      step();
      tests++; if (oGnt !== 4'b0001) begin fails++; $display("FAIL rstmid_ptr got %b exp %b", oGnt, 4'b0001); end
      iReq = '0;
      step();
      step();
   endtask

   task automatic test_latch();
      int found_at = -1;
      iReq[0] = 1'b1; iJ[0] = 1'b1; iK[0] = 1'b0; iIdx[0 +: IDXW] = 3'd4;
      step();
      tests++; if (oGnt !== 4'b0001) begin fails++; $display("FAIL latch_gnt0 got %b exp %b", oGnt, 4'b0001); end
      iReq[0] = 1'b0; iJ[0] = 1'b0; iK[0] = 1'b1; iIdx[0 +: IDXW] = 3'd4;
      iReq[2] = 1'b1; iJ[2] = 1'b1; iK[2] = 1'b0; iIdx[2*IDXW +: IDXW] = 3'd3;
      for (int n = 1; n <= 5; n++) begin
         step();
         if (oGnt[2] && found_at < 0) begin
            found_at = n;
            iReq[2] = 1'b0;
         end
         if (n == 2) begin
            tests++; if (oQ !== 6'b010000) begin fails++; $display("FAIL latch_q0 got %b exp %b", oQ, 6'b010000); end
         end
      end
      iReq[2] = 1'b0;
      tests++; if (found_at !== 3) begin fails++; $display("FAIL latch_gnt2_delay got %0d exp 3", found_at); end
      tests++; if (oQ !== 6'b011000) begin fails++; $display("FAIL latch_q2 got %b exp %b", oQ, 6'b011000); end
   endtask

   task automatic test_random();
      iRst = 1'b1;
      iReq = '0;
      step();
      iRst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (oGnt[r]) begin
               iReq[r] = 1'b0;
               iJ[r]   = 1'($urandom_range(0, 1));
               iK[r]   = 1'($urandom_range(0, 1));
               iIdx[r*IDXW +: IDXW] = IDXW'($urandom_range(0, 7));
            end else if (!iReq[r]) begin
               iJ[r] = 1'($urandom_range(0, 1));
               iK[r] = 1'($urandom_range(0, 1));
               iIdx[r*IDXW +: IDXW] = IDXW'($urandom_range(0, 7));
               if ($urandom_range(0, 99) < 30) iReq[r] = 1'b1;
            end else if ($urandom_range(0, 99) < 5) begin
               iReq[r] = 1'b0;
            end
         end
         iRst = ($urandom_range(0, 99) < 2);
         step();
         tests++; if (oGnt !== e_gnt) begin fails++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", c, oGnt, e_gnt); end
         tests++; if (oBusy !== e_busy) begin fails++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, oBusy, e_busy); end
         tests++; if (oErr !== e_err) begin fails++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, oErr, e_err); end
         tests++; if (oQ !== m_q) begin fails++; $display("FAIL rnd_q cyc %0d got %b exp %b", c, oQ, m_q); end
         tests++; if (oQn !== ~m_q) begin fails++; $display("FAIL rnd_qn cyc %0d got %b exp %b", c, oQn, ~m_q); end
      end
      iRst = 1'b0;
      iReq = '0;
   endtask

   initial begin
      iRst    = 1'b1;
      iReq    = '0;
      iJ      = '0;
      iK      = '0;
      iIdx    = '0;
      m_q     = '0;
      m_ptr   = 0;
      m_start = -1;
      m_t     = 0;
      m_j     = 1'b0;
      m_k     = 1'b0;
      m_idx   = 0;
      e_gnt   = '0;
      e_busy  = 1'b0;
      e_err   = 1'b0;
      test_reset();
      test_set();
      test_toggle_clear_hold();
      test_round_robin();
      test_err();
      test_reset_mid();
      test_latch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d tests", tests);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
